// File: rtl/rect_cyl_seq_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rect_cyl_seq_ctrl_if : request/result handshake bundle for rect_cyl_seq_ctrl
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
interface rect_cyl_seq_ctrl_if #(
  parameter int W = 8
);
  logic         ena;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic [W-1:0] theta;
  logic         busy;

  modport master (
    output ena, in_valid, x, y, out_ready,
    input  in_ready, out_valid, r, theta, busy
  );

  modport slave (
    input  ena, in_valid, x, y, out_ready,
    output in_ready, out_valid, r, theta, busy
  );
endinterface
`default_nettype wire

// File: rtl/rect_cyl_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rect_cyl_seq_ctrl : sequenced (x,y) -> (r, theta code) converter,
//                     bit-serial square root followed by restoring divider
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module rect_cyl_seq_ctrl #(
  parameter int W     = 8,
  parameter int DEG45 = 45,
  parameter int DEG90 = 90
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  rect_cyl_seq_ctrl_if.slave  bus
);
  localparam int SW = 2*W + 2;           // x^2+y^2 needs 2W+1 bits; padded to whole bit pairs
  localparam int RW = W + 4;             // root remainder incl. 2-bit shift headroom
  localparam int DW = W + 6;             // dividend x*DEG45
  localparam int CW = $clog2(W + 6);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SQRT = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [W-1:0] c_max   = {W{1'b1}};
  localparam logic [W-1:0] c_deg90 = W'(DEG90);

  logic [2:0]    r_state;
  logic [W-1:0]  r_x, r_y;
  logic [SW-1:0] r_sum;
  logic [RW-1:0] r_rem;
  logic [W:0]    r_root;
  logic [DW-1:0] r_dvd;                  // dividend bits shift out, quotient bits shift in
  logic [W-1:0]  r_drem;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_r, r_theta;

  logic [RW-1:0] w_rem_sh, w_trial, w_rem_nxt;
  logic          w_ge;
  logic [W:0]    w_drem_sh, w_ddiff;
  logic          w_dge;
  logic [DW-1:0] w_q;
  logic [W-1:0]  w_r_sat, w_theta;

  assign w_rem_sh  = RW'({r_rem, r_sum[SW-1:SW-2]});
  assign w_trial   = RW'({r_root, 2'b01});
  assign w_ge      = (w_rem_sh >= w_trial);
  assign w_rem_nxt = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;

  assign w_drem_sh = {r_drem, r_dvd[DW-1]};
  assign w_ddiff   = w_drem_sh - {1'b0, r_y};
  assign w_dge     = (w_drem_sh >= {1'b0, r_y});
  assign w_q       = {r_dvd[DW-2:0], w_dge};

  assign w_r_sat   = r_root[W] ? c_max : r_root[W-1:0];
  assign w_theta   = (r_y == '0) ? ((r_x == '0) ? '0 : c_deg90)
                   : ((|w_q[DW-1:W]) ? c_max : w_q[W-1:0]);

  assign bus.in_ready  = bus.ena && (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.r         = r_r;
  assign bus.theta     = r_theta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_sum   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_dvd   <= '0;
      r_drem  <= '0;
      r_cnt   <= '0;
      r_r     <= '0;
      r_theta <= '0;
    end else if (bus.ena) begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x     <= bus.x;
            r_y     <= bus.y;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sum   <= SW'(r_x) * SW'(r_x) + SW'(r_y) * SW'(r_y);
          r_dvd   <= DW'(r_x) * DW'(DEG45);
          r_rem   <= '0;
          r_root  <= '0;
          r_drem  <= '0;
          r_cnt   <= '0;
          r_state <= S_SQRT;
        end
        S_SQRT: begin
          r_sum  <= {r_sum[SW-3:0], 2'b00};
          r_rem  <= w_rem_nxt;
          r_root <= {r_root[W-1:0], w_ge};
          if (r_cnt == CW'(W)) begin
            r_cnt   <= '0;
            r_state <= S_DIV;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DIV: begin
          // divide-by-zero still runs the full length so latency never varies
          r_drem <= W'(w_dge ? w_ddiff : w_drem_sh);
          r_dvd  <= w_q;
          if (r_cnt == CW'(W + 5)) begin
            r_r     <= w_r_sat;
            r_theta <= w_theta;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rect_cyl_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rect_cyl_seq_ctrl : directed scoreboard bench for rect_cyl_seq_ctrl
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_rect_cyl_seq_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rect_cyl_seq_ctrl_if #(.W(W)) bus();
  rect_cyl_seq_ctrl #(.W(W), .DEG45(45), .DEG90(90)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] r;
    logic [7:0] t;
    int         lat;
    string      name;
  } exp_t;

  exp_t  sb[$];
  exp_t  m_e;
  int    n_cmp = 0;
  int    n_err = 0;
  int    edge_cnt = 0;
  logic  prev_ov = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: edges are counted from the accept edge; each rising out_valid pops one expectation
  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) edge_cnt = 0;
    else edge_cnt++;
    #1;
    if (bus.out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        m_e = sb.pop_front();
        chk({m_e.name, "_r"},     bus.r,     m_e.r);
        chk({m_e.name, "_theta"}, bus.theta, m_e.t);
        chk({m_e.name, "_lat"},   edge_cnt,  m_e.lat);
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] er,
                      input logic [7:0] et, input int lat, input string nm, input bit push);
    if (push) sb.push_back('{er, et, lat, nm});
    bus.x = x;
    bus.y = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x = 8'($urandom);
    bus.y = 8'($urandom);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (bus.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk({nm, "_timeout"}, 1, 0);
    @(negedge clk);
  endtask

  initial begin
    int bad;
    int k;
    bus.ena = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.x = '0;
    bus.y = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_r",         bus.r,         0);
    chk("rst_theta",     bus.theta,     0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_in_ready",  bus.in_ready,  1);
    @(negedge clk);

    send(8'd3, 8'd4, 8'd5, 8'd33, 24, "x3y4", 1'b1);
    bad = 0;
    for (int i = 0; i < 22; i++) begin
      if (!bus.busy || bus.in_ready || bus.out_valid) bad++;
      @(negedge clk);
    end
    chk("busy_throughout", bad, 0);
    wait_idle("x3y4");

    send(8'd255, 8'd255, 8'd255, 8'd45,  24, "x255y255", 1'b1); wait_idle("x255y255");
    send(8'd200, 8'd1,   8'd200, 8'd255, 24, "x200y1",   1'b1); wait_idle("x200y1");
    send(8'd0,   8'd0,   8'd0,   8'd0,   24, "x0y0",     1'b1); wait_idle("x0y0");
    send(8'd7,   8'd0,   8'd7,   8'd90,  24, "x7y0",     1'b1); wait_idle("x7y0");

    bus.ena = 1'b0;
    #1;
    chk("ena_low_in_ready", bus.in_ready, 0);
    bus.ena = 1'b1;
    send(8'd3, 8'd4, 8'd5, 8'd33, 29, "ena_stall", 1'b1);
    repeat (2) @(negedge clk);
    bus.ena = 1'b0;
    repeat (5) @(negedge clk);
    bus.ena = 1'b1;
    wait_idle("ena_stall");

    bus.out_ready = 1'b0;
    send(8'd3, 8'd4, 8'd5, 8'd33, 24, "hold", 1'b1);
    k = 0;
    while (!bus.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("hold_timeout", 1, 0);
    bus.x = 8'd9;
    bus.y = 8'd9;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.r != 8'd5 || bus.theta != 8'd33) bad++;
    end
    chk("done_hold", bad, 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_out_valid", bus.out_valid, 0);
    chk("hold_release_busy",      bus.busy,      0);
    chk("idle_r_held",            bus.r,         5);
    chk("idle_theta_held",        bus.theta,     33);

    send(8'd9, 8'd9, 8'd0, 8'd0, 0, "aborted", 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",      bus.busy,      0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_r",         bus.r,         0);
    chk("midrst_theta",     bus.theta,     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'd6, 8'd8, 8'd10, 8'd33, 24, "x6y8", 1'b1);
    wait_idle("x6y8");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
